add_stim_chk: RTL and testbench
===============================

ADD_STIM_CHK -- requirements
Module: add_stim_chk

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 2, the number of wait cycles between driving an operand pair and sampling sum (legal range 0..15).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request an exhaustive sweep; sampled only in IDLE or DONE.
REQ-006 a  output  4  operand A driven to the adder under test; registered.
REQ-007 b  output  4  operand B driven to the adder under test; registered.
REQ-008 sum  input  5  result returned by the adder under test.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high (level) once a sweep completes, until the next start or rst.
REQ-011 pass_cnt  output  9  number of vectors whose sum matched.
REQ-012 err_cnt  output  9  number of vectors whose sum mismatched.
REQ-013 err_flag  output  1  set on the first mismatch of a sweep; sticky until the next start or rst.
REQ-014 first_err_a, first_err_b, first_err_sum  output  4/4/5  operands and observed sum of the first mismatch.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-016 Transition IDLE->DRIVE: on an edge where start=1; vector index idx (8-bit) cleared to 0; all counters and first_err_* cleared.
REQ-017 Operand mapping: a=idx[7:4] and b=idx[3:0], registered on entry to DRIVE and held stable through CHECK.
REQ-018 Transition DRIVE->SETTLE: lasts 1 cycle; goes to SETTLE, or directly to CHECK when SETTLE=0.
REQ-019 SETTLE state: remains exactly SETTLE cycles (down-counter), then goes to CHECK.
REQ-020 CHECK state: lasts 1 cycle; compares sum against expected = zero-extended a + zero-extended b (5-bit, no truncation).
REQ-021 Match and mismatch accounting: on a match pass_cnt increments; on a mismatch err_cnt increments, and if err_flag=0, first_err_* capture a/b/sum and err_flag sets.
REQ-022 Sum containing any X/Z bit: SHALL count as a mismatch in simulation.
REQ-023 Transition out of CHECK: if idx=255, go to DONE; else idx increments and the FSM returns to DRIVE (no wrap of idx within a sweep).
REQ-024 Vector period: SHALL be SETTLE+2 cycles; a full sweep SHALL be 256*(SETTLE+2) cycles from the start-sampling edge to the edge that sets done.
REQ-025 busy: SHALL be 1 in DRIVE/SETTLE/CHECK and 0 in IDLE/DONE; done SHALL be 1 only in DONE.
REQ-026 start while busy: SHALL be ignored (no restart, no counter change).
REQ-027 start=1 in DONE: SHALL behave as in IDLE (done drops, counters clear, new sweep begins at idx=0).
REQ-028 Completion invariant: at done=1, pass_cnt+err_cnt SHALL equal 256.
REQ-029 Counter overflow: 9-bit counters cannot overflow within one sweep; no saturation logic is required.

Reset
REQ-030 Reset values: on an edge with rst=1, state=IDLE, and a, b, idx, busy, done, pass_cnt, err_cnt, err_flag and first_err_* SHALL all be 0.
REQ-031 rst priority: rst SHALL override start and any in-progress sweep on the same edge; the sweep is abandoned and no partial result is retained.

Verification
REQ-032 Correct combinational adder, SETTLE=2, 1-cycle start pulse -> busy=1 the next cycle; done rises 1024 cycles after the start edge; pass_cnt=256, err_cnt=0, err_flag=0.
REQ-033 Adder with sum[4] stuck at 0, SETTLE=2 -> err_cnt=120, pass_cnt=136, err_flag=1, first_err_a=1, first_err_b=15, first_err_sum=0.
REQ-034 Assert rst for 1 cycle 100 cycles into a sweep -> next cycle all outputs 0 and busy=0; a subsequent start yields a full 256-vector run with pass_cnt=256.
REQ-035 start held high for an entire sweep -> exactly one sweep runs while busy; the first cycle in DONE with start=1 restarts, done drops and counters read 0.
REQ-036 Adder with 1-cycle registered output and SETTLE=0 -> err_cnt>0 (first_err at a=0, b=1); the same adder with SETTLE=1 -> pass_cnt=256, done 768 cycles after start.

Source files
------------

// File: rtl/add_stim_chk_if.sv
// add_stim_chk_if: stimulus/check bus between the sweep controller and its environment
interface add_stim_chk_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] sum;
  logic       busy;
  logic       done;
  logic [8:0] pass_cnt;
  logic [8:0] err_cnt;
  logic       err_flag;
  logic [3:0] first_err_a;
  logic [3:0] first_err_b;
  logic [4:0] first_err_sum;
  modport master (
    output start, sum,
    input  a, b, busy, done, pass_cnt, err_cnt, err_flag, first_err_a, first_err_b, first_err_sum
  );
  modport slave (
    input  start, sum,
    output a, b, busy, done, pass_cnt, err_cnt, err_flag, first_err_a, first_err_b, first_err_sum
  );
endinterface

// File: rtl/add_stim_chk.sv
// add_stim_chk: exhaustive 4-bit adder stimulus generator and result checker
module add_stim_chk #(
  parameter int SETTLE = 2
) (
  input logic          clk,
  input logic          rst,
  add_stim_chk_if.slave bus
);
  typedef enum logic [2:0] {st_idle, st_drive, st_settle, st_check, st_done} state_t;
  state_t     state, state_nx;
  logic [7:0] idx;
  logic [3:0] cnt;
  logic       go;
  logic       match;
  assign go       = bus.start && (state == st_idle || state == st_done);
  // case equality so that an X/Z bit in sum is treated as a mismatch
  assign match    = bus.sum === ({1'b0, bus.a} + {1'b0, bus.b});
  assign bus.busy = state == st_drive || state == st_settle || state == st_check;
  assign bus.done = state == st_done;
  // state register
  always_ff @(posedge clk)
    state <= rst ? st_idle : state_nx;
  // next-state: drive -> settle (skipped when SETTLE=0) -> check -> next vector or done
  always_comb begin
    state_nx = go                    ? st_drive :
               state == st_drive     ? (SETTLE == 0 ? st_check : st_settle) :
               state == st_settle    ? (cnt == 4'd0 ? st_check : st_settle) :
               state == st_check     ? (idx == 8'hff ? st_done : st_drive) :
               state;
  end
  // operand registers, settle counter, vector index and result accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      idx               <= '0;
      cnt               <= '0;
      bus.a             <= '0;
      bus.b             <= '0;
      bus.pass_cnt      <= '0;
      bus.err_cnt       <= '0;
      bus.err_flag      <= 1'b0;
      bus.first_err_a   <= '0;
      bus.first_err_b   <= '0;
      bus.first_err_sum <= '0;
    end else if (go) begin
      idx               <= '0;
      bus.pass_cnt      <= '0;
      bus.err_cnt       <= '0;
      bus.err_flag      <= 1'b0;
      bus.first_err_a   <= '0;
      bus.first_err_b   <= '0;
      bus.first_err_sum <= '0;
    end else begin
      if (state == st_drive) begin
        bus.a <= idx[7:4];
        bus.b <= idx[3:0];
        cnt   <= 4'(SETTLE - 1);
      end
      if (state == st_settle)
        cnt <= cnt - 4'd1;
      if (state == st_check) begin
        idx <= idx == 8'hff ? idx : idx + 8'd1;
        if (match)
          bus.pass_cnt <= bus.pass_cnt + 9'd1;
        else begin
          bus.err_cnt <= bus.err_cnt + 9'd1;
          if (!bus.err_flag) begin
            bus.err_flag      <= 1'b1;
            bus.first_err_a   <= bus.a;
            bus.first_err_b   <= bus.b;
            bus.first_err_sum <= bus.sum;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_add_stim_chk.sv
// tb_add_stim_chk: directed tests of the adder sweep checker against good, stuck and registered adders
module tb_add_stim_chk;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode2 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;
  logic [4:0] s2, r0, r1;
  always #5 clk = ~clk;
  add_stim_chk_if i2 ();
  add_stim_chk_if i0 ();
  add_stim_chk_if i1 ();
  add_stim_chk #(.SETTLE(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
  add_stim_chk #(.SETTLE(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  add_stim_chk #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  assign s2     = {1'b0, i2.a} + {1'b0, i2.b};
  assign i2.sum = mode2 ? {1'b0, s2[3:0]} : s2;
  always_ff @(posedge clk) begin
    r0 <= {1'b0, i0.a} + {1'b0, i0.b};
    r1 <= {1'b0, i1.a} + {1'b0, i1.b};
  end
  assign i0.sum = r0;
  assign i1.sum = r1;

  task automatic start_pulse(input int sel);
    @(negedge clk);
    if (sel == 0) i0.start = 1'b1; else if (sel == 1) i1.start = 1'b1; else i2.start = 1'b1;
    @(posedge clk);
    #1;
    i0.start = 1'b0; i1.start = 1'b0; i2.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int cyc);
    logic d;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      d = sel == 0 ? i0.done : sel == 1 ? i1.done : i2.done;
    end while (!d && cyc < 3000);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (i2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", i2.busy); end
    checks++; if (i2.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", i2.done); end
    checks++; if ({i2.a, i2.b} !== 8'h00) begin errors++; $display("FAIL reset_ab got %h want 00", {i2.a, i2.b}); end
    checks++; if ({i2.pass_cnt, i2.err_cnt} !== 18'h0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", i2.pass_cnt, i2.err_cnt); end
    checks++; if ({i2.err_flag, i2.first_err_a, i2.first_err_b, i2.first_err_sum} !== 14'h0) begin errors++; $display("FAIL reset_err got %h want 0", {i2.err_flag, i2.first_err_a, i2.first_err_b, i2.first_err_sum}); end
    rst = 1'b0;
  endtask

  task automatic test_good_sweep;
    mode2 = 1'b0;
    start_pulse(2);
    checks++; if (i2.busy !== 1'b1) begin errors++; $display("FAIL good_busy got %0b want 1", i2.busy); end
    wait_done(2, n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL good_latency got %0d want 1024", n); end
    checks++; if (i2.pass_cnt !== 9'd256) begin errors++; $display("FAIL good_pass got %0d want 256", i2.pass_cnt); end
    checks++; if (i2.err_cnt !== 9'd0) begin errors++; $display("FAIL good_err got %0d want 0", i2.err_cnt); end
    checks++; if (i2.err_flag !== 1'b0) begin errors++; $display("FAIL good_flag got %0b want 0", i2.err_flag); end
    checks++; if (i2.busy !== 1'b0) begin errors++; $display("FAIL good_busy_done got %0b want 0", i2.busy); end
  endtask

  task automatic test_stuck_bit;
    mode2 = 1'b1;
    start_pulse(2);
    wait_done(2, n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL stuck_latency got %0d want 1024", n); end
    checks++; if (i2.err_cnt !== 9'd120) begin errors++; $display("FAIL stuck_err got %0d want 120", i2.err_cnt); end
    checks++; if (i2.pass_cnt !== 9'd136) begin errors++; $display("FAIL stuck_pass got %0d want 136", i2.pass_cnt); end
    checks++; if (i2.err_flag !== 1'b1) begin errors++; $display("FAIL stuck_flag got %0b want 1", i2.err_flag); end
    checks++; if ({i2.first_err_a, i2.first_err_b, i2.first_err_sum} !== {4'd1, 4'd15, 5'd0}) begin errors++; $display("FAIL stuck_first got a=%0d b=%0d s=%0d want a=1 b=15 s=0", i2.first_err_a, i2.first_err_b, i2.first_err_sum); end
    mode2 = 1'b0;
  endtask

  task automatic test_reset_mid;
    start_pulse(2);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({i2.busy, i2.done, i2.err_flag} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b want 000", {i2.busy, i2.done, i2.err_flag}); end
    checks++; if ({i2.pass_cnt, i2.err_cnt} !== 18'h0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", i2.pass_cnt, i2.err_cnt); end
    checks++; if ({i2.a, i2.b} !== 8'h00) begin errors++; $display("FAIL midrst_ab got %h want 00", {i2.a, i2.b}); end
    @(negedge clk);
    rst = 1'b0;
    start_pulse(2);
    wait_done(2, n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL midrst_latency got %0d want 1024", n); end
    checks++; if (i2.pass_cnt !== 9'd256) begin errors++; $display("FAIL midrst_pass got %0d want 256", i2.pass_cnt); end
  endtask

  task automatic test_start_held;
    @(negedge clk);
    i2.start = 1'b1;
    @(posedge clk);
    wait_done(2, n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL held_latency got %0d want 1024", n); end
    checks++; if (i2.pass_cnt + i2.err_cnt !== 256) begin errors++; $display("FAIL held_total got %0d want 256", i2.pass_cnt + i2.err_cnt); end
    @(posedge clk);
    #1;
    checks++; if ({i2.done, i2.busy} !== 2'b01) begin errors++; $display("FAIL held_restart got done=%0b busy=%0b want done=0 busy=1", i2.done, i2.busy); end
    checks++; if ({i2.pass_cnt, i2.err_cnt} !== 18'h0) begin errors++; $display("FAIL held_cnt got %0d/%0d want 0/0", i2.pass_cnt, i2.err_cnt); end
    i2.start = 1'b0;
  endtask

  task automatic test_registered_adder;
    start_pulse(0);
    wait_done(0, n);
    checks++; if (n !== 512) begin errors++; $display("FAIL reg0_latency got %0d want 512", n); end
    checks++; if (i0.err_cnt === 9'd0) begin errors++; $display("FAIL reg0_err got %0d want >0", i0.err_cnt); end
    checks++; if ({i0.first_err_a, i0.first_err_b} !== {4'd0, 4'd1}) begin errors++; $display("FAIL reg0_first got a=%0d b=%0d want a=0 b=1", i0.first_err_a, i0.first_err_b); end
    checks++; if (i0.pass_cnt + i0.err_cnt !== 256) begin errors++; $display("FAIL reg0_total got %0d want 256", i0.pass_cnt + i0.err_cnt); end
    start_pulse(1);
    wait_done(1, n);
    checks++; if (n !== 768) begin errors++; $display("FAIL reg1_latency got %0d want 768", n); end
    checks++; if (i1.pass_cnt !== 9'd256) begin errors++; $display("FAIL reg1_pass got %0d want 256", i1.pass_cnt); end
    checks++; if (i1.err_flag !== 1'b0) begin errors++; $display("FAIL reg1_flag got %0b want 0", i1.err_flag); end
  endtask

  initial begin
    i0.start = 1'b0;
    i1.start = 1'b0;
    i2.start = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    test_good_sweep;
    test_stuck_bit;
    test_reset_mid;
    test_start_held;
    test_registered_adder;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
